hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It watches the ID, EX and MEM stages and produces hold and flush controls for the PC, IF_ID, ID_EX and EX_MEM registers. It resolves three conditions: load-use hazards, taken-branch redirects and multi-cycle DRAM accesses. It also flags a DRAM timeout as a sticky error. It sits beside the stage registers in the top-level pipeline and contains no datapath.

## Interface
- `DRAM_TIMEOUT`, default 8: maximum MEM_WAIT cycles before the error state; legal range 2..255.
- `LOAD_SEL`, default 2'b01: `wd_sel` encoding that marks a DRAM load.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rs1_id`, `rs2_id`  in  5 each  source registers of the instruction in ID.
- `re1_id`, `re2_id`  in  1 each  the source is actually read.
- `valid_ex`  in  1  EX holds a real instruction.
- `rf_we_ex`  in  1  EX instruction writes the register file.
- `wd_sel_ex`  in  2  write-data select of the EX instruction.
- `wR_ex`  in  5  destination register of the EX instruction.
- `branch_taken_ex`  in  1  EX resolved a taken branch or jump.
- `dram_req_mem`  in  1  MEM stage performs a DRAM load or store.
- `dram_ack`  in  1  DRAM completes the access this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`  out  1 each  hold the register.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a bubble (valid=0, write enables=0).
- `mem_err`  out  1  sticky DRAM timeout.

## Operation
- Three states: RUN, MEM_WAIT and ERR. Reset enters RUN with `wait_cnt` = 0.
- While `rst_n` is low, every output is 0.

RUN, decoded in strict priority order:
1. Memory wait: `dram_req_mem & ~dram_ack`.
   - Assert all four stalls; no flushes.
   - Next state is MEM_WAIT with `wait_cnt` = 0.
2. Branch: `branch_taken_ex & valid_ex`.
   - Assert `if_id_flush` and `id_ex_flush`; no stalls.
3. Load-use: `valid_ex & rf_we_ex & wd_sel_ex==LOAD_SEL & wR_ex!=0`, and the EX destination matches a source in ID (`re1_id` with `rs1_id==wR_ex`, or `re2_id` with `rs2_id==wR_ex`).
   - Assert `pc_stall`, `if_id_stall` and `id_ex_flush`.
4. Otherwise all outputs are 0.

MEM_WAIT:
- All four stalls are asserted; flushes are 0.
- With `dram_ack`=1:
  - Outputs decode exactly as RUN priorities 2–4 in that same cycle. A branch held in EX is therefore flushed on the release cycle.
  - Next state is RUN.
- With `dram_ack`=0:
  - `wait_cnt` increments.
  - If `wait_cnt==DRAM_TIMEOUT-1`, next state is ERR.

ERR:
- All four stalls are held and `mem_err`=1.
- Only reset exits this state.

Other rules:
- `dram_ack` asserted without `dram_req_mem` is ignored.
- A load-use match on `wR_ex`=0 never stalls.

## Timing
- Stall and flush outputs are combinational from the state and the current inputs. The stage registers act on them at the next edge.
- A load-use hazard costs exactly 1 bubble. The hazard clears by itself once the load advances.
- DRAM access, measured from the first `dram_req_mem` cycle:
  - Ack in the same cycle: 0 stall cycles.
  - Ack N cycles later: N stall cycles.
- Without an ack, MEM_WAIT lasts `DRAM_TIMEOUT` cycles. `mem_err` rises at the edge after the last one.
- `mem_err` is registered; it is 0 until ERR is entered.
- `wait_cnt` is `$clog2(DRAM_TIMEOUT)` bits wide and saturates; it is cleared on every RUN→MEM_WAIT transition.
- Asserting `rst_n` low mid-wait or in ERR immediately forces RUN and 0 on every output, including `mem_err`.

## Configuration
- `HAZARD_CTRL_PERF_EN`:
  - When defined, adds outputs `stall_cycles[31:0]` and `flush_events[31:0]`, both reset to 0.
  - `stall_cycles` increments in every cycle `pc_stall` is 1.
  - `flush_events` increments in every cycle `id_ex_flush` is 1.
  - Both counters wrap at 2^32.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Load-use: load with `wR_ex`=5, ID `rs1_id`=5, `re1_id`=1 → one cycle of `pc_stall`=`if_id_stall`=`id_ex_flush`=1; all outputs 0 the next cycle.
- Same load with `wR_ex`=0, or with `re1_id`=0 → no stall and no flush.
- Branch taken together with a load-use match → only `if_id_flush`=`id_ex_flush`=1; `pc_stall`=0.
- `dram_req_mem`=1 with `dram_ack` arriving 3 cycles later → 3 cycles with all stalls=1; release cycle stalls=0 and state is RUN.
- `DRAM_TIMEOUT`=8, ack never arrives, request at cycle t0 → stalls held from t0; `mem_err`=1 from the edge ending cycle t0+8 and held; `rst_n` pulse clears it to 0.
- `HAZARD_CTRL_PERF_EN` defined, previous scenario → `stall_cycles` is 9 at `mem_err` rise; `flush_events` is unchanged.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencing controller for the 5-stage RISC-V core.
//            Generates hold (stall) and bubble (flush) controls for the PC,
//            IF_ID, ID_EX and EX_MEM registers from load-use hazards,
//            taken-branch redirects and multi-cycle DRAM accesses, and
//            raises a sticky error when a DRAM access times out.
// Ports    : clk, rst_n (async, active-low)
//            rs1_id/rs2_id, re1_id/re2_id          - ID-stage source regs
//            valid_ex, rf_we_ex, wd_sel_ex, wR_ex  - EX-stage writer info
//            branch_taken_ex                       - EX redirect
//            dram_req_mem, dram_ack                - MEM-stage DRAM handshake
//            pc_stall, if_id_stall, id_ex_stall, ex_mem_stall - holds
//            if_id_flush, id_ex_flush              - bubble insertion
//            mem_err                               - sticky DRAM timeout
//            stall_cycles, flush_events            - perf counters (optional)
// Options  : HAZARD_CTRL_PERF_EN adds the two 32-bit performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int         DRAM_TIMEOUT = 8,
    parameter logic [1:0] LOAD_SEL     = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       re1_id,
    input  logic       re2_id,
    input  logic       valid_ex,
    input  logic       rf_we_ex,
    input  logic [1:0] wd_sel_ex,
    input  logic [4:0] wR_ex,
    input  logic       branch_taken_ex,
    input  logic       dram_req_mem,
    input  logic       dram_ack,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       ex_mem_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       mem_err
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    localparam int                CNT_W    = $clog2(DRAM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic load_use;
    logic branch;
    logic mem_wait;
    logic pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c;
    logic if_id_flush_c, id_ex_flush_c;

    // A write to x0 is never a real dependency, so wR_ex==0 is excluded.
    assign load_use = valid_ex & rf_we_ex & (wd_sel_ex == LOAD_SEL) &
                      (wR_ex != 5'd0) &
                      ((re1_id & (rs1_id == wR_ex)) |
                       (re2_id & (rs2_id == wR_ex)));
    assign branch   = branch_taken_ex & valid_ex;
    assign mem_wait = dram_req_mem & ~dram_ack;

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    {pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c} = 4'hF;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (branch) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dram_ack) begin
                    // Release cycle: the pipeline moves again, so a branch or
                    // load-use held behind the access is resolved right now.
                    state_d = RUN;
                    if (branch) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (load_use) begin
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end
                end else begin
                    {pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c} = 4'hF;
                    if (wait_cnt_q == CNT_LAST) begin
                        state_d = ERR;
                    end
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            ERR: begin
                {pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c} = 4'hF;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs are combinational from inputs, so they are forced low while
    // reset is asserted rather than relying on the state register alone.
    assign pc_stall     = rst_n & pc_stall_c;
    assign if_id_stall  = rst_n & if_id_stall_c;
    assign id_ex_stall  = rst_n & id_ex_stall_c;
    assign ex_mem_stall = rst_n & ex_mem_stall_c;
    assign if_id_flush  = rst_n & if_id_flush_c;
    assign id_ex_flush  = rst_n & id_ex_flush_c;
    assign mem_err      = (state_q == ERR);

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, flush_events_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (id_ex_flush) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule
`default_nettype wire
